// File: rtl/argmax_stream_pkg.sv
// Shared data types and default widths for the streaming block-argmax and the CFO path.
package argmax_stream_pkg;

    localparam int unsigned LAMBDA_W  = 14;  // signed Q6.8
    localparam int unsigned ANG_W     = 11;  // signed Q3.8
    localparam int unsigned EPS_W     = 21;  // signed Q1.20
    localparam int unsigned PI_W      = 8;   // unsigned Q0.8
    localparam int unsigned EPS_SHIFT = 4;   // 8+8 fractional bits up to 20

    localparam logic [PI_W-1:0] INV2PI = 8'd40;

    typedef logic signed [LAMBDA_W-1:0] lambda_t;
    typedef logic signed [ANG_W-1:0]    ang_t;
    typedef logic signed [EPS_W-1:0]    eps_t;

    typedef enum logic {
        S_SKIP = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    // Bits needed to index 0..n-1 (at least one bit).
    function automatic int unsigned theta_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_eps_scale.sv
// Combinational CFO scaling: eps = ang * (1/2pi), realigned to Q1.20 and truncated.
module argmax_eps_scale
    import argmax_stream_pkg::*;
#(
    parameter int unsigned     ANG_W  = argmax_stream_pkg::ANG_W,
    parameter int unsigned     EPS_W  = argmax_stream_pkg::EPS_W,
    parameter int unsigned     PI_W   = argmax_stream_pkg::PI_W,
    parameter logic [PI_W-1:0] INV2PI = argmax_stream_pkg::INV2PI
) (
    input  logic signed [ANG_W-1:0] ang,
    output logic signed [EPS_W-1:0] eps_c
);

    localparam int unsigned PROD_W = ANG_W + PI_W + 1;
    localparam int unsigned SH_W   = PROD_W + EPS_SHIFT;

    logic signed [PROD_W-1:0] ang_ext;
    logic signed [PROD_W-1:0] k_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [SH_W-1:0]   shifted;

    // Signed multiply by the zero-extended constant, shift to 20 frac bits, wrap to EPS_W.
    always_comb begin
        ang_ext = PROD_W'(ang);
        k_ext   = $signed(PROD_W'({1'b0, INV2PI}));
        prod    = ang_ext * k_ext;
        shifted = $signed({prod, {EPS_SHIFT{1'b0}}});
        eps_c   = EPS_W'(shifted);
    end

endmodule

// File: rtl/argmax_stream.sv
// Streaming block-argmax over N (lambda, angle) beats with a handshaked result register.
// Optional threshold detect output when ARGMAX_STREAM_THRESH_EN is defined.
module argmax_stream
    import argmax_stream_pkg::*;
#(
    parameter int unsigned N        = 256,
    parameter int unsigned SKIP     = 283,
    parameter int unsigned LAMBDA_W = argmax_stream_pkg::LAMBDA_W,
    parameter int unsigned ANG_W    = argmax_stream_pkg::ANG_W,
    parameter int unsigned EPS_W    = argmax_stream_pkg::EPS_W,
    parameter logic [argmax_stream_pkg::PI_W-1:0] INV2PI = argmax_stream_pkg::INV2PI,
    parameter bit          TIE_LAST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       sof,
    input  logic signed [LAMBDA_W-1:0] lambda_in,
    input  logic signed [ANG_W-1:0]    angle_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(N)-1:0]       theta_out,
    output logic signed [EPS_W-1:0]    eps_out,
    output logic signed [LAMBDA_W-1:0] peak_out,
    output logic                       ovf
`ifdef ARGMAX_STREAM_THRESH_EN
    ,
    input  logic signed [LAMBDA_W-1:0] thresh_in,
    output logic                       detect
`endif
);

    localparam int unsigned IDX_W  = theta_w(N);
    localparam int unsigned SKIP_W = theta_w(SKIP + 1);
    localparam state_t      RST_STATE = (SKIP == 0) ? S_ACC : S_SKIP;

    state_t                      state;
    logic [SKIP_W-1:0]           skip_cnt;
    logic [IDX_W-1:0]            pos;
    logic signed [LAMBDA_W-1:0]  max_q;
    logic signed [ANG_W-1:0]     ang_q;
    logic [IDX_W-1:0]            idx_q;

    logic                        win_c;
    logic                        last_c;
    logic signed [LAMBDA_W-1:0]  sel_max_c;
    logic signed [ANG_W-1:0]     sel_ang_c;
    logic [IDX_W-1:0]            sel_idx_c;
    logic signed [EPS_W-1:0]     eps_c;

    // Post-update selection for the current beat, so the final beat can still win.
    always_comb begin
        win_c = 1'b1;
        if (pos != '0) begin
            win_c = TIE_LAST ? (lambda_in >= max_q) : (lambda_in > max_q);
        end
        sel_max_c = win_c ? lambda_in : max_q;
        sel_ang_c = win_c ? angle_in  : ang_q;
        sel_idx_c = win_c ? pos       : idx_q;
        last_c    = in_valid && !sof && (state == S_ACC) && (pos == IDX_W'(N - 1));
    end

    argmax_eps_scale #(
        .ANG_W  (ANG_W),
        .EPS_W  (EPS_W),
        .PI_W   (argmax_stream_pkg::PI_W),
        .INV2PI (INV2PI)
    ) u_eps_scale (
        .ang   (sel_ang_c),
        .eps_c (eps_c)
    );

    // Skip/accumulate FSM, running maximum and the handshaked result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            skip_cnt  <= '0;
            pos       <= '0;
            max_q     <= '0;
            ang_q     <= '0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            theta_out <= '0;
            eps_out   <= '0;
            peak_out  <= '0;
            ovf       <= 1'b0;
`ifdef ARGMAX_STREAM_THRESH_EN
            detect    <= 1'b0;
`endif
        end else begin
            if (in_valid) begin
                if (sof) begin
                    // Resync: this beat becomes pos 0 of a fresh block.
                    state    <= S_ACC;
                    skip_cnt <= '0;
                    pos      <= IDX_W'(1);
                    max_q    <= lambda_in;
                    ang_q    <= angle_in;
                    idx_q    <= '0;
                end else if (state == S_SKIP) begin
                    if (skip_cnt == SKIP_W'(SKIP - 1)) begin
                        state    <= S_ACC;
                        skip_cnt <= '0;
                    end else begin
                        skip_cnt <= skip_cnt + 1'b1;
                    end
                end else begin
                    max_q <= sel_max_c;
                    ang_q <= sel_ang_c;
                    idx_q <= sel_idx_c;
                    pos   <= last_c ? '0 : pos + 1'b1;
                end
            end

            if (last_c) begin
                out_valid <= 1'b1;
                theta_out <= sel_idx_c;
                eps_out   <= eps_c;
                peak_out  <= sel_max_c;
`ifdef ARGMAX_STREAM_THRESH_EN
                detect    <= (sel_max_c >= thresh_in);
`endif
                if (out_valid && !out_ready) begin
                    ovf <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
